// File: rtl/vga_mode_ctrl.sv
// Video mode reconfiguration controller: accepts a mode request, optionally waits for the
// end of the current frame, then holds the timing generator in reset while new timings load.
module vga_mode_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_valid,
  input  logic [1:0]  mode_sel,
  output logic        mode_ready,
  input  logic        frame_end,
  output logic        vga_rst_n,
  output logic [15:0] H_Sync,
  output logic [15:0] H_BP,
  output logic [15:0] H_Act,
  output logic [15:0] H_FP,
  output logic [15:0] V_Sync,
  output logic [15:0] V_BP,
  output logic [15:0] V_Act,
  output logic [15:0] V_FP,
  output logic [1:0]  mode_cur,
  output logic        cfg_done,
  output logic        err,
  output logic        wait_to
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, HOLD} state_e;

  typedef struct packed {
    logic [15:0] h_sync, h_bp, h_act, h_fp;
    logic [15:0] v_sync, v_bp, v_act, v_fp;
  } timing_t;

  function automatic timing_t mode_timing(input logic [1:0] m);
    case (m)
      2'd0:    return '{16'd96, 16'd48,  16'd640,  16'd16,  16'd2, 16'd33, 16'd480,  16'd10};
      2'd1:    return '{16'd40, 16'd220, 16'd1280, 16'd110, 16'd5, 16'd20, 16'd720,  16'd5};
      2'd2:    return '{16'd44, 16'd148, 16'd1920, 16'd88,  16'd5, 16'd36, 16'd1080, 16'd4};
      default: return '0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [21:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  mode_cur_q, mode_cur_d;
  timing_t     timing_q, timing_d;
  logic        running_q, running_d;
  logic        mode_ready_q, mode_ready_d;
  logic        vga_rst_n_q, vga_rst_n_d;
  logic        cfg_done_q, cfg_done_d;
  logic        err_q, err_d;
  logic        wait_to_q, wait_to_d;

  logic accept, legal, timeout_hit, hold_last, enter_hold;
  logic [1:0] tgt_mode;

  assign accept      = mode_valid && mode_ready_q;
  assign legal       = (mode_sel != 2'd3);
  assign timeout_hit = (wait_cnt_q == 22'(TIMEOUT - 1));
  assign hold_last   = (hold_cnt_q == 8'(HOLD_CYCLES - 1));

  // NOTE: sync reset clears every register, including the timing table outputs, so an aborted
  // reconfiguration leaves the generator in reset with zeroed parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      mode_q       <= '0;
      mode_cur_q   <= '0;
      timing_q     <= '0;
      running_q    <= 1'b0;
      mode_ready_q <= 1'b0;
      vga_rst_n_q  <= 1'b0;
      cfg_done_q   <= 1'b0;
      err_q        <= 1'b0;
      wait_to_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      mode_q       <= mode_d;
      mode_cur_q   <= mode_cur_d;
      timing_q     <= timing_d;
      running_q    <= running_d;
      mode_ready_q <= mode_ready_d;
      vga_rst_n_q  <= vga_rst_n_d;
      cfg_done_q   <= cfg_done_d;
      err_q        <= err_d;
      wait_to_q    <= wait_to_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept && legal) state_d = running_q ? WAIT_FRAME : HOLD;
      WAIT_FRAME: if (frame_end || timeout_hit) state_d = HOLD;
      HOLD:       if (hold_last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    enter_hold   = (state_d == HOLD) && (state_q != HOLD);
    // From IDLE the mode goes straight to HOLD, so it is taken from the request itself.
    tgt_mode     = (state_q == IDLE) ? mode_sel : mode_q;
    mode_d       = (state_q == IDLE && accept && legal) ? mode_sel : mode_q;
    wait_cnt_d   = (state_q == WAIT_FRAME) ? wait_cnt_q + 22'd1 : '0;
    hold_cnt_d   = (state_q == HOLD && !hold_last) ? hold_cnt_q + 8'd1 : '0;
    mode_ready_d = (state_d == IDLE);
    err_d        = (state_q == IDLE) && accept && !legal;
    wait_to_d    = (state_q == WAIT_FRAME) && !frame_end && timeout_hit;
    cfg_done_d   = (state_q == HOLD) && hold_last;
    running_d    = running_q || cfg_done_d;
    vga_rst_n_d  = vga_rst_n_q;
    if (enter_hold)      vga_rst_n_d = 1'b0;
    else if (cfg_done_d) vga_rst_n_d = 1'b1;
    timing_d     = enter_hold ? mode_timing(tgt_mode) : timing_q;
    mode_cur_d   = enter_hold ? tgt_mode : mode_cur_q;
  end

  assign mode_ready = mode_ready_q;
  assign vga_rst_n  = vga_rst_n_q;
  assign H_Sync     = timing_q.h_sync;
  assign H_BP       = timing_q.h_bp;
  assign H_Act      = timing_q.h_act;
  assign H_FP       = timing_q.h_fp;
  assign V_Sync     = timing_q.v_sync;
  assign V_BP       = timing_q.v_bp;
  assign V_Act      = timing_q.v_act;
  assign V_FP       = timing_q.v_fp;
  assign mode_cur   = mode_cur_q;
  assign cfg_done   = cfg_done_q;
  assign err        = err_q;
  assign wait_to    = wait_to_q;

endmodule
